// File: rtl/d5m_capture_ctrl.sv
// d5m_capture_ctrl: AXI4-Lite controlled D5M frame capture sequencer; watchdog enabled by D5M_CAPTURE_TIMEOUT_EN.
// Latency: capture_en is combinational from ifval/ilval; AXI write response and read data one cycle after handshake.
// Backpressure: one outstanding write and one read; new handshakes are held off until BVALID/RVALID are consumed.
module d5m_capture_ctrl #(
    parameter int unsigned PIX_DEFAULT    = 1280,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        ifval,
    input  logic        ilval,
    input  logic [7:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [7:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        capture_en,
    output logic        frame_done,
    output logic        busy,
    output logic        irq
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [11:0] EXP_RST = 12'(PIX_DEFAULT);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t      state_q, state_d;
    logic        ifval_q, ilval_q;
    logic [11:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [11:0] pixels_q, pixels_d, lines_q, lines_d, exp_pix_q, exp_pix_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        cont_q, cont_d, irq_en_q, irq_en_d;
    logic        done_q, done_d, len_err_q, len_err_d;
    logic        timeout_q, timeout_set;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_fire, rd_fire, wr_ctrl, wr_stat, start_cmd, abort_cmd;
    logic        sof, eof, in_capture, line_close, frame_end;
    logic [11:0] line_inc;

    // Bus handshakes, commands and camera edge events
    always_comb begin
        wr_fire    = AWVALID & WVALID & ~bvalid_q;
        rd_fire    = ARVALID & ~rvalid_q;
        wr_ctrl    = wr_fire & (AWADDR == 8'h00) & WSTRB[0];
        wr_stat    = wr_fire & (AWADDR == 8'h04) & WSTRB[0];
        start_cmd  = wr_ctrl & WDATA[0];
        abort_cmd  = wr_ctrl & WDATA[2];
        sof        = ifval & ~ifval_q;
        eof        = ~ifval & ifval_q;
        in_capture = (state_q == ST_CAPTURE);
        // A line still open when the frame ends is closed together with the frame
        line_close = in_capture & ilval_q & (~ilval | eof) & ~abort_cmd;
        frame_end  = in_capture & eof & ~abort_cmd;
        // Qualify the sof cycle too, so the first pixel of a frame is not lost
        capture_en = ifval & ilval & (in_capture | ((state_q == ST_WAIT_SOF) & sof));
    end

    // Sequencer next state; abort overrides everything including a same-cycle start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_cmd) state_d = ifval ? ST_ARM : ST_WAIT_SOF;
            ST_ARM:      if (!ifval) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (sof) state_d = ST_CAPTURE;
            ST_CAPTURE:  if (eof) state_d = ST_DONE;
            ST_DONE:     state_d = cont_q ? ST_WAIT_SOF : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (timeout_set) state_d = ST_IDLE;
        if (abort_cmd) state_d = ST_IDLE;
    end

    // Geometry counters, register file updates and AXI response channels
    always_comb begin
        line_inc    = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 12'd1;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        pixels_d    = pixels_q;
        lines_d     = lines_q;
        frame_cnt_d = frame_cnt_q;
        if (capture_en && pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 12'd1;
        if (line_close) begin
            pixels_d   = pix_cnt_q;
            pix_cnt_d  = '0;
            line_cnt_d = line_inc;
        end
        if (frame_end) begin
            lines_d     = line_close ? line_inc : line_cnt_q;
            line_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (abort_cmd) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end

        cont_d    = cont_q;
        irq_en_d  = irq_en_q;
        exp_pix_d = exp_pix_q;
        if (wr_ctrl) begin
            cont_d   = WDATA[1];
            irq_en_d = WDATA[3];
        end
        if (wr_fire && AWADDR == 8'h14) begin
            if (WSTRB[0]) exp_pix_d[7:0]  = WDATA[7:0];
            if (WSTRB[1]) exp_pix_d[11:8] = WDATA[11:8];
        end
        // Hardware set takes priority over a same-cycle write-one-to-clear
        done_d    = (done_q & ~(wr_stat & WDATA[1])) | frame_end;
        len_err_d = (len_err_q & ~(wr_stat & WDATA[2])) | (line_close & (pix_cnt_q != exp_pix_q));

        bvalid_d = bvalid_q ? ~BREADY : wr_fire;
        rvalid_d = rvalid_q ? ~RREADY : rd_fire;
        rdata_d  = rdata_q;
        if (rd_fire) begin
            case (ARADDR)
                8'h00:   rdata_d = {28'd0, irq_en_q, 1'b0, cont_q, 1'b0};
                8'h04:   rdata_d = {25'd0, state_q, timeout_q, len_err_q, done_q, busy};
                8'h08:   rdata_d = {16'd0, frame_cnt_q};
                8'h0C:   rdata_d = {20'd0, lines_q};
                8'h10:   rdata_d = {20'd0, pixels_q};
                8'h14:   rdata_d = {20'd0, exp_pix_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // State, counters and register file
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            ifval_q     <= 1'b0;
            ilval_q     <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            pixels_q    <= '0;
            lines_q     <= '0;
            frame_cnt_q <= '0;
            exp_pix_q   <= EXP_RST;
            cont_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ifval_q     <= ifval;
            ilval_q     <= ilval;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            pixels_q    <= pixels_d;
            lines_q     <= lines_d;
            frame_cnt_q <= frame_cnt_d;
            exp_pix_q   <= exp_pix_d;
            cont_q      <= cont_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef D5M_CAPTURE_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        timeout_d;

    // Watchdog: counts cycles spent waiting for a frame start, restarts on any state change
    always_comb begin
        timeout_set = ((state_q == ST_ARM) || (state_q == ST_WAIT_SOF)) &&
                      (wd_q == TIMEOUT_CYCLES - 24'd1);
        wd_d        = (state_d != state_q) ? 24'd0 : wd_q + 24'd1;
        if (state_q != ST_ARM && state_q != ST_WAIT_SOF) wd_d = 24'd0;
        timeout_d   = (timeout_q & ~(wr_stat & WDATA[3])) | timeout_set;
    end

    // Watchdog registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{WDATA[31:12], WSTRB[3:2]};
`else
    assign timeout_set = 1'b0;
    assign timeout_q   = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{WDATA[31:12], WSTRB[3:2], TIMEOUT_CYCLES};
`endif

    assign AWREADY    = wr_fire;
    assign WREADY     = wr_fire;
    assign ARREADY    = rd_fire;
    assign BVALID     = bvalid_q;
    assign BRESP      = 2'b00;
    assign RVALID     = rvalid_q;
    assign RDATA      = rdata_q;
    assign RRESP      = 2'b00;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign irq        = (done_q | timeout_q) & irq_en_q;
endmodule

// File: tb/tb_d5m_capture_ctrl.sv
// tb_d5m_capture_ctrl: randomized frame stimulus against a geometry-level reference model of d5m_capture_ctrl.
// Latency: AXI transactions are driven on negedges and sampled away from the rising edge.
// Backpressure: BREADY/RREADY held high, so responses are consumed the cycle they appear.
module tb_d5m_capture_ctrl;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        ifval = 1'b0, ilval = 1'b0;
    logic [7:0]  AWADDR = '0, ARADDR = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
    logic        BREADY = 1'b1, RREADY = 1'b1;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic        capture_en, frame_done, busy, irq;

    d5m_capture_ctrl #(.PIX_DEFAULT(1280), .TIMEOUT_CYCLES(24'd100)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ifval(ifval), .ilval(ilval),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .capture_en(capture_en), .frame_done(frame_done), .busy(busy), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    int cap_cnt = 0;
    int fd_cnt = 0;

    // Observed pixel-qualifier cycles and frame_done cycles
    always @(negedge ACLK) begin
        if (capture_en) cap_cnt <= cap_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    // Reference model state
    int   m_frames = 0;
    logic m_done = 1'b0, m_lerr = 1'b0, m_to = 1'b0, m_irq_en = 1'b0;
    int   f_nl;
    int   f_lens[8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp(input logic [2:0] st);
        return {25'd0, st, m_to, m_lerr, m_done, (st != 3'd0)};
    endfunction

    function automatic int exp_pixels_total();
        int s = 0;
        for (int l = 0; l < f_nl; l++) s += f_lens[l];
        return s;
    endfunction

    function automatic logic exp_len_err(input int ep);
        logic e = 1'b0;
        for (int l = 0; l < f_nl; l++) if (f_lens[l] != ep) e = 1'b1;
        return e;
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 16) begin @(negedge ACLK); n++; end
        check_eq("awready", {31'd0, AWREADY & WREADY}, 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 16) begin @(negedge ACLK); n++; end
        check_eq("bvalid", {31'd0, BVALID}, 32'd1);
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 16) begin @(negedge ACLK); n++; end
        check_eq("arready", {31'd0, ARREADY}, 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 16) begin @(negedge ACLK); n++; end
        check_eq("rvalid", {31'd0, RVALID}, 32'd1);
        d = RDATA;
        @(posedge ACLK); #1;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic play_frame(input int porch, input int hgap, input int tail, input int vgap);
        logic [1:0] seq[$];
        repeat (porch) seq.push_back(2'b10);
        for (int l = 0; l < f_nl; l++) begin
            repeat (f_lens[l]) seq.push_back(2'b11);
            if (l != f_nl - 1) repeat (hgap) seq.push_back(2'b10);
        end
        repeat (tail) seq.push_back(2'b10);
        repeat (vgap) seq.push_back(2'b00);
        foreach (seq[i]) begin
            @(negedge ACLK);
            {ifval, ilval} = seq[i];
        end
    endtask

    task automatic set_uniform(input int nl, input int len);
        f_nl = nl;
        for (int l = 0; l < 8; l++) f_lens[l] = len;
    endtask

    task automatic clear_status();
        axi_write(8'h04, 32'h0000_000E, 4'h1);
        m_done = 1'b0; m_lerr = 1'b0; m_to = 1'b0;
    endtask

    // Checks common to every fully captured frame
    task automatic check_frame(input string tag, input int cap0, input int fd0, input int nframes);
        check_eq({tag, "_cap"}, cap_cnt - cap0, exp_pixels_total());
        check_eq({tag, "_fdone"}, fd_cnt - fd0, nframes);
        read_check({tag, "_lines"}, 8'h0C, f_nl);
        read_check({tag, "_pixels"}, 8'h10, f_lens[f_nl - 1]);
        read_check({tag, "_fcnt"}, 8'h08, m_frames & 16'hFFFF);
        read_check({tag, "_status"}, 8'h04, status_exp(3'd0));
        check_eq({tag, "_irq"}, irq, (m_done | m_to) & m_irq_en);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  reg_addr[7];
        logic [31:0] reg_rst[7];
        int cap0, fd0, ep;
        reg_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        reg_rst  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1280, 32'd0};

        // Reset state
        repeat (3) @(negedge ACLK);
        check_eq("rst_outs", {capture_en, frame_done, busy, irq, AWREADY, WREADY, ARREADY, BVALID, RVALID},
                 32'd0);
        check_eq("rst_rdata", RDATA, 32'd0);
        check_eq("rst_resp", {BRESP, RRESP}, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 7; i++) read_check("rst_reg", reg_addr[i], reg_rst[i]);

        // Byte lanes on EXP_PIX and ignored unmapped write
        axi_write(8'h14, 32'h0000_0A08, 4'b0001);
        read_check("exp_lane0", 8'h14, 32'h508);
        axi_write(8'h14, 32'hFFF0_0A0C, 4'b0010);
        read_check("exp_lane1", 8'h14, 32'hA08);
        axi_write(8'h18, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped", 8'h18, 32'd0);

        // Single 4x8 frame with START|IRQ_EN
        axi_write(8'h14, 32'd8, 4'hF);
        axi_write(8'h00, 32'h9, 4'h1);
        m_irq_en = 1'b1;
        read_check("ctrl_selfclr", 8'h00, 32'h8);
        set_uniform(4, 8);
        cap0 = cap_cnt; fd0 = fd_cnt;
        play_frame(1, 2, 1, 3);
        m_frames++; m_done = 1'b1;
        check_frame("basic", cap0, fd0, 1);
        check_eq("basic_busy", busy, 1'b0);

        // START mid-frame: partial frame skipped, next frame captured
        clear_status();
        cap0 = cap_cnt; fd0 = fd_cnt;
        fork
            play_frame(3, 2, 1, 4);
            begin
                repeat (3) @(negedge ACLK);
                axi_write(8'h00, 32'h9, 4'h1);
                read_check("mid_arm", 8'h04, status_exp(3'd1));
            end
        join
        check_eq("mid_partial_cap", cap_cnt - cap0, 32'd0);
        read_check("mid_wait", 8'h04, status_exp(3'd2));
        play_frame(0, 1, 0, 3);
        m_frames++; m_done = 1'b1;
        check_frame("mid_full", cap0, fd0, 1);

        // Continuous mode: three frames, short line in frame 2, CONT dropped during frame 3
        clear_status();
        axi_write(8'h00, 32'hB, 4'h1);
        cap0 = cap_cnt; fd0 = fd_cnt;
        set_uniform(3, 8);
        play_frame(1, 2, 1, 3);
        set_uniform(4, 8);
        f_lens[2] = 7;
        play_frame(0, 1, 1, 3);
        cap0 = cap0 + 31;
        set_uniform(3, 8);
        fork
            play_frame(2, 2, 1, 4);
            begin
                repeat (6) @(negedge ACLK);
                axi_write(8'h00, 32'h8, 4'h1);
            end
        join
        cap0 = cap0 + 24;
        m_frames += 3; m_done = 1'b1; m_lerr = 1'b1;
        check_frame("cont", cap0, fd0, 3);
        axi_write(8'h04, 32'h4, 4'h1);
        m_lerr = 1'b0;
        read_check("cont_w1c", 8'h04, status_exp(3'd0));

        // ABORT during CAPTURE
        clear_status();
        axi_write(8'h00, 32'h9, 4'h1);
        set_uniform(4, 8);
        fd0 = fd_cnt;
        fork
            play_frame(1, 2, 1, 3);
            begin
                repeat (10) @(negedge ACLK);
                axi_write(8'h00, 32'hC, 4'h1);
                check_eq("abort_busy", busy, 1'b0);
            end
        join
        check_eq("abort_fdone", fd_cnt - fd0, 32'd0);
        read_check("abort_fcnt", 8'h08, m_frames & 16'hFFFF);
        read_check("abort_status", 8'h04, status_exp(3'd0));
        check_eq("abort_irq", irq, 1'b0);

        // START together with ABORT stays idle
        axi_write(8'h00, 32'hD, 4'h1);
        read_check("start_abort", 8'h04, status_exp(3'd0));

        // Randomized single frames
        for (int it = 0; it < 4; it++) begin
            clear_status();
            ep = $urandom_range(3, 12);
            axi_write(8'h14, ep, 4'hF);
            f_nl = $urandom_range(1, 5);
            for (int l = 0; l < 8; l++) begin
                f_lens[l] = ep;
                if ($urandom_range(0, 3) == 0) f_lens[l] = ($urandom_range(0, 1) != 0) ? ep + 1 : ep - 1;
            end
            axi_write(8'h00, 32'h9, 4'h1);
            cap0 = cap_cnt; fd0 = fd_cnt;
            play_frame($urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(3, 5));
            m_frames++; m_done = 1'b1; m_lerr = exp_len_err(ep);
            check_frame("rand", cap0, fd0, 1);
        end

`ifdef D5M_CAPTURE_TIMEOUT_EN
        // Watchdog expiry while waiting for a frame start
        clear_status();
        axi_write(8'h00, 32'h9, 4'h1);
        repeat (50) @(negedge ACLK);
        check_eq("to_waiting", busy, 1'b1);
        repeat (60) @(negedge ACLK);
        check_eq("to_idle", busy, 1'b0);
        m_to = 1'b1;
        read_check("to_status", 8'h04, status_exp(3'd0));
        check_eq("to_irq", irq, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/d5m_capture_ctrl.md
Name: d5m_capture_ctrl

Overview:
AXI4-Lite controlled capture sequencer for the D5M camera input path. It arms on software command and aligns to frame boundaries on ifval/ilval. It gates pixel capture into the downstream colour pipeline with capture_en, measures line and frame geometry, checks line length, and raises done and irq per frame. ifval/ilval arrive already synchronised to ACLK.

Parameters:
PIX_DEFAULT, 1280, reset value of EXP_PIX (expected pixels per line)
TIMEOUT_CYCLES, 24'd10000000, WAIT_SOF watchdog limit (used only with the optional feature)

Ports:
ACLK  in  1  system clock; all logic is on the rising edge
ARESETN  in  1  asynchronous active-low reset
ifval  in  1  camera frame valid
ilval  in  1  camera line valid
AWADDR  in  8  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes; byte lanes honoured
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  always 2'b00
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  8  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  always 2'b00
RVALID  out  1  read data valid
RREADY  in  1  read data ready
capture_en  out  1  pixel qualifier to the downstream pipeline
frame_done  out  1  one-cycle pulse at the end of a captured frame
busy  out  1  state is not IDLE
irq  out  1  level interrupt: STATUS.done & CTRL.irq_en

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; all counters 0; CTRL 0; EXP_PIX = PIX_DEFAULT.
- AXI write:
  - AWREADY and WREADY pulse together for 1 cycle when AWVALID & WVALID & !BVALID.
  - BVALID asserts the next cycle and holds until BREADY.
- AXI read:
  - ARREADY pulses for 1 cycle when ARVALID & !RVALID.
  - RDATA/RVALID are registered on the next cycle and held until RREADY.
- Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 CTRL (RW): b0 START, self-clearing; b1 CONT; b2 ABORT, self-clearing; b3 IRQ_EN.
  - 0x04 STATUS: b0 busy (RO); b1 done (W1C); b2 len_err (W1C); b3 timeout (W1C); b6:4 state (RO).
  - 0x08 FRAME_CNT[15:0] (RO): wraps at 16 bits.
  - 0x0C LINES[11:0] (RO): line count of the last frame.
  - 0x10 PIXELS[11:0] (RO): pixel count of the last line.
  - 0x14 EXP_PIX[11:0] (RW).
- State encoding: IDLE=0, ARM=1, WAIT_SOF=2, CAPTURE=3, DONE=4.
- Transitions:
  - IDLE: on START, go to ARM if ifval=1, else WAIT_SOF. This prevents starting on a partial frame.
  - ARM: wait for ifval=0, then go to WAIT_SOF.
  - WAIT_SOF: on sof (ifval & !ifval_q), go to CAPTURE.
  - CAPTURE: on eof (!ifval & ifval_q), go to DONE.
  - DONE: lasts 1 cycle, then WAIT_SOF if CONT=1, else IDLE.
- capture_en is combinational: ifval & ilval & (state==CAPTURE | (state==WAIT_SOF & sof)). There is zero latency, so the first pixel of the frame is kept.
- Pixel counter:
  - Increments on every capture_en cycle and saturates at 4095.
  - On line end (ilval_q & !ilval) inside CAPTURE:
    - PIXELS <= count and the counter clears.
    - Line counter increments and saturates at 4095.
    - If count != EXP_PIX, set len_err.
- At eof:
  - LINES <= line count; FRAME_CNT increments.
  - done is set and frame_done pulses in the DONE cycle.
  - Line counter clears.
  - A line still open at eof is closed the same cycle, with its PIXELS update and length check.
- ABORT:
  - From any state, go to IDLE next cycle.
  - No done, no frame_done; FRAME_CNT unchanged; counters cleared.
  - ABORT wins over a simultaneous START.
- A hardware set and a W1C of the same STATUS bit in the same cycle: set wins.
- START while busy is ignored.
- CONT cleared during CAPTURE: the current frame completes, then the block returns to IDLE.

Optional Feature:
- D5M_CAPTURE_TIMEOUT_EN defined:
  - A 24-bit watchdog counts cycles in ARM and WAIT_SOF and clears on state exit.
  - When it reaches TIMEOUT_CYCLES, STATUS.timeout is set and the next state is IDLE.
  - irq = (done | timeout) & IRQ_EN.
- Not defined: no watchdog logic; STATUS b3 reads 0; irq = done & IRQ_EN.

Test Plan:
- Reset, then read all registers:
  - EXP_PIX = 1280; all other registers 0.
  - All outputs 0.
- Write EXP_PIX=8 and CTRL=0x9, then drive a 4-line by 8-pixel frame starting with ifval low:
  - capture_en high for exactly 32 cycles.
  - LINES=4, PIXELS=8, FRAME_CNT=1.
  - frame_done pulses once; irq=1; len_err=0; state returns to IDLE.
- START issued mid-frame (ifval=1):
  - State goes to ARM.
  - The partial frame is not captured and capture_en stays 0.
  - The next full frame is captured.
- CONT=1 with 3 frames, the third line of frame 2 being 7 pixels:
  - FRAME_CNT=3; len_err=1.
  - Write 0x4 to STATUS: len_err clears.
- ABORT during CAPTURE:
  - busy=0 the next cycle.
  - FRAME_CNT unchanged; no frame_done.
  - START together with ABORT: stays in IDLE.
- With D5M_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100, START with ifval held 0:
  - timeout=1 after 100 cycles; state IDLE; irq=1.
